// File: rtl/branch_control_unit_if.sv
// Control bundle between the branch control sequencer and the datapath.
// The sequencer side (master) reads IR, CON_out and Stop and drives every
// control strobe; the datapath side (slave) sees the opposite directions.
interface branch_control_unit_if;
   logic        Stop;
   logic [31:0] IR;
   logic        CON_out;

   logic        PCout;
   logic        Zlowout;
   logic        MDRout;
   logic        Cout;
   logic        MARin;
   logic        Zin;
   logic        PCin;
   logic        MDRin;
   logic        IRin;
   logic        Yin;
   logic        IncPC;
   logic        Read;
   logic        Write;
   logic        Gra;
   logic        Grb;
   logic        Grc;
   logic        Rin;
   logic        Rout;
   logic        BAout;
   logic        CON_in;
   logic [4:0]  operation;
   logic        Run;

   modport master (
      input  Stop, IR, CON_out,
      output PCout, Zlowout, MDRout, Cout, MARin, Zin, PCin, MDRin, IRin, Yin,
             IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, CON_in,
             operation, Run
   );

   modport slave (
      output Stop, IR, CON_out,
      input  PCout, Zlowout, MDRout, Cout, MARin, Zin, PCin, MDRin, IRin, Yin,
             IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, CON_in,
             operation, Run
   );
endinterface

// File: rtl/branch_control_unit.sv
// Hardwired control sequencer for fetch plus the control-flow group
// (br, jr, nop, halt). Strobes are decoded from the current state only,
// except PCin in BR6, which follows the datapath CON flip-flop directly.
module branch_control_unit #(
   parameter logic [4:0] OP_ADD  = 5'b00011,
   parameter logic [4:0] OP_BR   = 5'b10010,
   parameter logic [4:0] OP_JR   = 5'b10011,
   parameter logic [4:0] OP_NOP  = 5'b11001,
   parameter logic [4:0] OP_HALT = 5'b11010
) (
   input  logic                        Clock,
   input  logic                        Reset,
   branch_control_unit_if.master       bus
);

   typedef enum logic [3:0] {
      ST_RST,
      ST_T0,
      ST_T1,
      ST_T2,
      ST_DEC,
      ST_BR3,
      ST_BR4,
      ST_BR5,
      ST_BR6,
      ST_JR3,
      ST_HALT
   } state_t;

   state_t state_q, state_d;
   logic   stop_pending_q, stop_pending_d;
   logic   stop_now;
   state_t fetch_or_halt;
   logic [4:0] opcode;

   assign opcode = bus.IR[31:27];

   // State and pending-stop registers; Reset abandons any instruction in flight
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q        <= ST_RST;
         stop_pending_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         stop_pending_q <= stop_pending_d;
      end
   end

   // Next-state logic; a Stop seen in the current cycle counts as pending
   // so a request on the final cycle of an instruction still halts it
   always_comb begin
      stop_now       = stop_pending_q | bus.Stop;
      stop_pending_d = stop_now;
      fetch_or_halt  = stop_now ? ST_HALT : ST_T0;
      state_d        = state_q;
      case (state_q)
         ST_RST:  state_d = ST_T0;
         ST_T0:   state_d = ST_T1;
         ST_T1:   state_d = ST_T2;
         ST_T2:   state_d = ST_DEC;
         ST_DEC: begin
            if (opcode == OP_BR)        state_d = ST_BR3;
            else if (opcode == OP_JR)   state_d = ST_JR3;
            else if (opcode == OP_HALT) state_d = ST_HALT;
            else                        state_d = fetch_or_halt;
         end
         ST_BR3:  state_d = ST_BR4;
         ST_BR4:  state_d = ST_BR5;
         ST_BR5:  state_d = ST_BR6;
         ST_BR6:  state_d = fetch_or_halt;
         ST_JR3:  state_d = fetch_or_halt;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_RST;
      endcase
   end

   // Control strobe decode; everything idle unless the state names it
   always_comb begin
      bus.PCout     = 1'b0;
      bus.Zlowout   = 1'b0;
      bus.MDRout    = 1'b0;
      bus.Cout      = 1'b0;
      bus.MARin     = 1'b0;
      bus.Zin       = 1'b0;
      bus.PCin      = 1'b0;
      bus.MDRin     = 1'b0;
      bus.IRin      = 1'b0;
      bus.Yin       = 1'b0;
      bus.IncPC     = 1'b0;
      bus.Read      = 1'b0;
      bus.Write     = 1'b0;
      bus.Gra       = 1'b0;
      bus.Grb       = 1'b0;
      bus.Grc       = 1'b0;
      bus.Rin       = 1'b0;
      bus.Rout      = 1'b0;
      bus.BAout     = 1'b0;
      bus.CON_in    = 1'b0;
      bus.operation = 5'b00000;
      bus.Run       = 1'b1;
      case (state_q)
         ST_T0: begin
            bus.PCout = 1'b1;
            bus.MARin = 1'b1;
            bus.IncPC = 1'b1;
            bus.Zin   = 1'b1;
         end
         ST_T1: begin
            bus.Zlowout = 1'b1;
            bus.PCin    = 1'b1;
            bus.Read    = 1'b1;
            bus.MDRin   = 1'b1;
         end
         ST_T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
         end
         ST_BR3: begin
            bus.Gra    = 1'b1;
            bus.Rout   = 1'b1;
            bus.CON_in = 1'b1;
         end
         ST_BR4: begin
            bus.PCout = 1'b1;
            bus.Yin   = 1'b1;
         end
         ST_BR5: begin
            bus.Cout      = 1'b1;
            bus.Zin       = 1'b1;
            bus.operation = OP_ADD;
         end
         ST_BR6: begin
            bus.Zlowout = 1'b1;
            bus.PCin    = bus.CON_out;
         end
         ST_JR3: begin
            bus.Gra  = 1'b1;
            bus.Rout = 1'b1;
            bus.PCin = 1'b1;
         end
         ST_HALT: bus.Run = 1'b0;
         default: ;
      endcase
   end

endmodule

// File: doc/branch_control_unit.md
Name: branch_control_unit

Overview:
- Hardwired control sequencer that drives the datapath control inputs that benches currently drive by hand.
- Runs instruction fetch, then executes the control-flow group: br (covers brzr/brnz/brpl/brmi through the datapath CON FF), jr, nop and halt.
- Sits beside the datapath. Reads IR contents and CON_out; produces one-hot-per-state (Moore) control strobes.

Parameters:
- OP_ADD, 5'b00011, ALU operation code used for PC + C.
- OP_BR, 5'b10010, IR[31:27] opcode for branch.
- OP_JR, 5'b10011, IR[31:27] opcode for jump-register.
- OP_NOP, 5'b11001, IR[31:27] opcode for no-op.
- OP_HALT, 5'b11010, IR[31:27] opcode for halt.

Ports:
- Clock  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high
- Stop  in  1  request halt at next instruction boundary
- IR  in  32  instruction register contents (datapath IR_data_out)
- CON_out  in  1  branch condition FF output from datapath
- PCout, Zlowout, MDRout, Cout  out  1 each  bus drivers
- MARin, Zin, PCin, MDRin, IRin, Yin  out  1 each  register loads
- IncPC, Read, Write  out  1 each  PC increment / memory strobes
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  select-and-encode controls
- CON_in  out  1  load CON FF
- operation  out  5  ALU operation select
- Run  out  1  high while executing, low in HALT

Behaviour:
- States: RST, T0, T1, T2, BR3, BR4, BR5, BR6, JR3, HALT. State register updates on posedge Clock.
- Outputs are decoded combinationally from the state only; every strobe asserted for exactly one full cycle.
- Reset=1 at any posedge (including mid-instruction) -> state RST next cycle.
- In RST: all outputs 0, operation=0, Run=1.
- RST -> T0 unconditionally.
- T0: PCout, MARin, IncPC, Zin. operation=0. Z gets PC+1.
- T1: Zlowout, PCin, Read, MDRin. PC gets PC+1; MDR gets Mem[MAR].
- T2: MDRout, IRin. IR valid from the next cycle.
- T2 -> T3 decode uses IR[31:27], sampled in the cycle after T2. The decode state is entered directly, with no extra cycle.
  - OP_BR -> BR3
  - OP_JR -> JR3
  - OP_HALT -> HALT
  - OP_NOP or any unrecognised opcode -> T0 (5-cycle latency, 3 fetch + 2 overhead absorbed)
  - Correction: decode is evaluated on the T2->next edge from IR input as it becomes valid. To avoid a race, T2 always goes to a DEC state: add DEC state, no outputs, then branch as above. A nop therefore takes T0,T1,T2,DEC = 4 cycles.
- BR3: Gra, Rout, CON_in. CON FF evaluated from Ra and IR[20:19].
- BR4: PCout, Yin.
- BR5: Cout, Zin, operation=OP_ADD. Z gets PC + sign-extended C.
- BR6: Zlowout. PCin is asserted only if CON_out=1, with CON_out sampled combinationally in BR6. CON_out=0 -> no PCin, PC unchanged.
- BR6 -> T0. A branch takes 8 cycles (T0..T2, DEC, BR3..BR6).
- JR3: Gra, Rout, PCin. JR3 -> T0. A jump takes 5 cycles.
- Stop=1 sampled in any cycle latches a pending flag (cleared by Reset). When entering T0 with the flag set, go to HALT instead. The instruction in flight always completes.
- HALT: all outputs 0, Run=0. HALT stays in HALT until Reset.
- Write, Grb, Grc, Rin, BAout, MDRout outside T2, and Cout outside BR5 are never asserted. They exist for port compatibility with the full controller.
- At most one bus driver (PCout, Zlowout, MDRout, Rout, Cout) is high in any state.

Test Plan:
- Reset held 2 cycles, then released with IR=nop (32'hC8000000) -> states RST,T0,T1,T2,DEC,T0. Run=1 throughout. Only the listed strobes fire.
- IR=32'h90180023 (br, C2=11), CON_out=1 in BR6 -> PCin high in BR6 together with Zlowout, operation=5'b00011 in BR5. Back in T0 after 8 cycles.
- Same br with CON_out=0 -> Zlowout=1 and PCin=0 in BR6. Next T0 follows.
- IR=32'h98800000 (jr R1) -> JR3 asserts Gra, Rout, PCin simultaneously. T0 follows.
- Stop pulsed for 1 cycle during BR4 -> branch completes through BR6, then HALT. Run=0 and all strobes 0 for 10+ cycles.
- Reset asserted in BR5 -> RST on next edge with all outputs 0, then T0. A check asserts no two bus drivers are ever high in the same cycle.
